// File: rtl/alu_operand_loader_if.sv
// Operand-entry bundle between the front-panel inputs and the ALU operand loader.
// The slave side is the loader; the master side is the panel/ALU environment.
interface alu_operand_loader_if #(
   parameter int M = 4
);
   logic [M-1:0] sw;
   logic         btn_load;
   logic         clr;
   logic [M-1:0] a_out;
   logic [M-1:0] b_out;
   logic         valid;
   logic         done;
   logic [1:0]   state;

   modport master (
      output sw, btn_load, clr,
      input  a_out, b_out, valid, done, state
   );

   modport slave (
      input  sw, btn_load, clr,
      output a_out, b_out, valid, done, state
   );
endinterface

// File: rtl/alu_operand_loader.sv
// Captures ALU operands A then B from switches on debounced button presses and
// holds them with a valid level until the next press returns to A entry.
//
// state   | meaning
// --------+-------------------------------------------------
// LOAD_A  | waiting for press to capture operand A
// LOAD_B  | A held, waiting for press to capture operand B
// READY   | pair complete, valid high; press restarts entry
module alu_operand_loader #(
   parameter int M  = 4,
   parameter int DB = 4
) (
   input logic              clk,
   input logic              rst,
   alu_operand_loader_if.slave bus
);

   localparam int CW = $clog2(DB + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB - 1);

   localparam logic [1:0] LOAD_A  = 2'b00;
   localparam logic [1:0] LOAD_B  = 2'b01;
   localparam logic [1:0] READY   = 2'b10;

   logic          sync1;
   logic          bs;
   logic          bd;
   logic [CW-1:0] cnt;
   logic          press;

   logic [1:0]    state;
   logic [M-1:0]  a_reg;
   logic [M-1:0]  b_reg;
   logic          valid;
   logic          done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         bs    <= 1'b0;
      end else begin
         sync1 <= bus.btn_load;
         bs    <= sync1;
      end
   end

   // bd flips after DB consecutive disagreeing cycles; press marks only the rising flip
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bd    <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (bs == bd) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            bd    <= ~bd;
            cnt   <= '0;
            press <= ~bd;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOAD_A;
         a_reg <= '0;
         b_reg <= '0;
         valid <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (bus.clr) begin
            state <= LOAD_A;
            a_reg <= '0;
            b_reg <= '0;
            valid <= 1'b0;
         end else begin
            case (state)
               LOAD_A: begin
                  if (press) begin
                     a_reg <= bus.sw;
                     state <= LOAD_B;
                  end
               end
               LOAD_B: begin
                  if (press) begin
                     b_reg <= bus.sw;
                     valid <= 1'b1;
                     done  <= 1'b1;
                     state <= READY;
                  end
               end
               READY: begin
                  if (press) begin
                     valid <= 1'b0;
                     state <= LOAD_A;
                  end
               end
               default: begin
                  valid <= 1'b0;
                  state <= LOAD_A;
               end
            endcase
         end
      end
   end

   assign bus.a_out = a_reg;
   assign bus.b_out = b_reg;
   assign bus.valid = valid;
   assign bus.done  = done;
   assign bus.state = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader: each press pushes the expected
// operand/state snapshot, which is popped when the DUT state changes.
module tb_alu_operand_loader;

   localparam int M  = 4;
   localparam int DB = 4;

   typedef struct {
      logic [M-1:0] a;
      logic [M-1:0] b;
      logic         valid;
      logic [1:0]   state;
      logic         done;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   exp_t         sb[$];
   logic [M-1:0] m_a;
   logic [M-1:0] m_b;
   logic         m_valid;
   logic [1:0]   m_state;

   alu_operand_loader_if #(.M(M)) bus ();

   alu_operand_loader #(.M(M), .DB(DB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_outputs(input string nm, input exp_t e);
      checks++;
      if (bus.a_out !== e.a || bus.b_out !== e.b || bus.valid !== e.valid ||
          bus.state !== e.state || bus.done !== e.done) begin
         failures++;
         $display("FAIL %s: got a=%b b=%b valid=%b state=%b done=%b, want a=%b b=%b valid=%b state=%b done=%b",
                  nm, bus.a_out, bus.b_out, bus.valid, bus.state, bus.done,
                  e.a, e.b, e.valid, e.state, e.done);
      end
   endtask

   function automatic exp_t model_snapshot(input logic done_exp);
      exp_t e;
      e.a = m_a; e.b = m_b; e.valid = m_valid; e.state = m_state; e.done = done_exp;
      return e;
   endfunction

   // Advances the reference model by one press and queues the resulting snapshot.
   task automatic model_press(input logic [M-1:0] v);
      logic d;
      d = 1'b0;
      case (m_state)
         2'b00: begin m_a = v; m_state = 2'b01; end
         2'b01: begin m_b = v; m_valid = 1'b1; m_state = 2'b10; d = 1'b1; end
         default: begin m_valid = 1'b0; m_state = 2'b00; end
      endcase
      sb.push_back(model_snapshot(d));
   endtask

   task automatic press(input logic [M-1:0] v, input string nm);
      exp_t       e;
      int         n;
      logic [1:0] st0;
      model_press(v);
      @(negedge clk);
      bus.sw       = v;
      bus.btn_load = 1'b1;
      st0 = bus.state;
      n = 0;
      while (bus.state === st0 && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n != DB + 3) begin
         failures++;
         $display("FAIL %s_latency: got %0d edges, want %0d", nm, n, DB + 3);
      end
      e = sb.pop_front();
      check_outputs(nm, e);
      if (e.done) begin
         @(posedge clk); #1;
         checks++;
         if (bus.done !== 1'b0 || bus.valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_width: got done=%b valid=%b, want done=0 valid=1",
                     nm, bus.done, bus.valid);
         end
      end
      @(negedge clk);
      bus.btn_load = 1'b0;
      repeat (DB + 4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      bus.sw = '0; bus.btn_load = 1'b0; bus.clr = 1'b0;
      rst = 1'b0;
      #3 rst = 1'b1;
      #1;
      m_a = '0; m_b = '0; m_valid = 1'b0; m_state = 2'b00;
      e = model_snapshot(1'b0);
      check_outputs("reset_assert", e);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset_release", e);
   endtask

   task automatic test_normal_entry();
      press(4'b1011, "load_a");
      press(4'b0001, "load_b");
   endtask

   task automatic test_cycle_back();
      press(4'b1111, "ready_exit");
      press(4'b0110, "reload_a");
   endtask

   task automatic test_bounce();
      exp_t e;
      int   changes;
      e = model_snapshot(1'b0);
      changes = 0;
      bus.sw = 4'b1100;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((i % 2) == 0) bus.btn_load = ~bus.btn_load;
         if (bus.state !== e.state) changes++;
      end
      @(negedge clk) bus.btn_load = 1'b0;
      repeat (DB + 6) @(posedge clk);
      #1;
      checks++;
      if (changes != 0) begin
         failures++;
         $display("FAIL bounce_changes: got %0d state changes, want 0", changes);
      end
      check_outputs("bounce_final", e);
   endtask

   task automatic test_clear_priority();
      exp_t e;
      int   dones;
      @(negedge clk);
      bus.sw       = 4'b1001;
      bus.btn_load = 1'b1;
      repeat (DB + 2) @(posedge clk);
      @(negedge clk);
      bus.clr = 1'b1;
      checks++;
      if (dut.press !== 1'b1) begin
         failures++;
         $display("FAIL clr_press_align: got press=%b, want 1", dut.press);
      end
      m_a = '0; m_b = '0; m_valid = 1'b0; m_state = 2'b00;
      e = model_snapshot(1'b0);
      @(posedge clk); #1;
      check_outputs("clr_priority", e);
      @(negedge clk) bus.clr = 1'b0;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.done !== 1'b0) dones++;
      end
      @(negedge clk) bus.btn_load = 1'b0;
      repeat (DB + 4) @(posedge clk);
      #1;
      checks++;
      if (dones != 0) begin
         failures++;
         $display("FAIL clr_done: got %0d done cycles, want 0", dones);
      end
      check_outputs("clr_settled", e);
   endtask

   task automatic test_hold();
      exp_t       e;
      int         changes;
      logic [1:0] prev;
      model_press(4'b0101);
      @(negedge clk);
      bus.sw       = 4'b0101;
      bus.btn_load = 1'b1;
      prev    = bus.state;
      changes = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (bus.state !== prev) begin
            changes++;
            prev = bus.state;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check_outputs("hold_capture", e);
            end
         end
      end
      checks++;
      if (changes != 1) begin
         failures++;
         $display("FAIL hold_count: got %0d captures, want 1", changes);
      end
      @(negedge clk) bus.btn_load = 1'b0;
      repeat (DB + 4) @(posedge clk);
      #1;
      check_outputs("hold_final", model_snapshot(1'b0));
   endtask

   task automatic test_async_reset();
      exp_t e;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      m_a = '0; m_b = '0; m_valid = 1'b0; m_state = 2'b00;
      e = model_snapshot(1'b0);
      check_outputs("async_reset", e);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_normal_entry();
      test_cycle_back();
      test_bounce();
      test_clear_priority();
      test_hold();
      test_async_reset();
      press(4'b0011, "post_reset_a");
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Operand entry stage that sits directly upstream of the M-bit ALU operation units (shift-left, shift-right, add, etc.). It samples a raw push-button and M slide switches. It synchronizes and debounces the button, then captures operand A and operand B on successive presses. Once both are held stable, it presents them to the ALU with a valid level. The ALU's combinational R/C/N/V/Z outputs are meaningful only while `valid` is high.

## Interface
- `M`, 4, operand width; must match the downstream ALU `M`.
- `DB`, 4, debounce length in clock cycles, ≥ 1.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high; clears all state immediately.
- `sw`  input  M  operand switches, sampled directly at the capture edge (quasi-static).
- `btn_load`  input  1  raw, asynchronous, bouncing load button, active-high.
- `clr`  input  1  synchronous clear, active-high, already clean and synchronous to `clk`.
- `a_out`  output  M  operand A to ALU (A = shiftee for shift ops).
- `b_out`  output  M  operand B to ALU (B = shift amount for shift ops).
- `valid`  output  1  high while `a_out`/`b_out` form a complete pair.
- `done`  output  1  one-cycle pulse on the cycle `valid` first rises.
- `state`  output  2  current FSM state, for LEDs: 00 LOAD_A, 01 LOAD_B, 10 READY.

## Operation
- Button path:
  - A 2-flop synchronizer turns `btn_load` into `bs`.
  - A debounce counter, DB-capable width, counts consecutive cycles in which `bs` differs from the debounced level `bd`.
  - Any cycle where `bs == bd` resets the counter to 0.
  - When the count reaches DB, `bd` toggles and the counter clears.
  - A 0→1 toggle of `bd` produces `press`, an internal pulse exactly one cycle long.
- Holding the button yields exactly one `press`. The next press requires `bd` to return to 0, which takes DB stable-low cycles.
- Bounces shorter than DB cycles produce no `press`.
- FSM, with `clr` taking priority over `press`:
  - LOAD_A, on `press`: `a_out <= sw`, go to LOAD_B.
  - LOAD_B, on `press`: `b_out <= sw`, `valid <= 1`, `done <= 1` for one cycle, go to READY.
  - READY, on `press`: `valid <= 0`, go to LOAD_A. `a_out`/`b_out` retain their values until overwritten.
  - Any state, on `clr`: `a_out <= 0`, `b_out <= 0`, `valid <= 0`, `done <= 0`, go to LOAD_A. The `press` of that same cycle is discarded.
  - Encoding 11 is illegal and recovers to LOAD_A on the next edge with `valid = 0`.
- `a_out`/`b_out` change only on a capture edge, `clr`, or `rst`. They never change while `valid = 1`.
- There is no arithmetic in this block. `sw` is copied bit-for-bit with no width conversion.

## Timing
- Reset values (asserted asynchronously, held while `rst = 1`):
  - `a_out = 0`, `b_out = 0`, `valid = 0`, `done = 0`, `state = 00`.
  - Synchronizer flops, `bd`, and the counter are all 0.
- Press latency, for `btn_load` rising cleanly and staying high before edge 0:
  - `bs` is high after edge 1.
  - The counter reaches DB at edge DB+1, so `bd` and `press` are high after edge DB+1.
  - The capture register and state update at edge DB+2.
- `done` is high for exactly the cycle after the LOAD_B capture edge, coincident with `valid` first reading 1.
- `valid` falls on the edge that consumes the READY press, or on `clr`.
- Release latency: after `btn_load` falls, `bd` returns to 0 at edge DB+1. A new rise is accepted only after that.
- `rst` deasserted mid-press: the synchronizer restarts from 0. A still-held button produces one `press` DB+2 edges later.

## Test plan
1. Reset with `M=4`, `DB=4`: assert `rst` mid-cycle -> all outputs 0 immediately and `state = 00`. Deassert -> outputs unchanged.
2. Normal entry:
   - `sw = 4'b1011`, clean press -> `a_out = 1011` at edge DB+2, `state = 01`.
   - Release, then `sw = 4'b0001`, press -> `b_out = 0001`, `valid = 1`, `done` high for one cycle, `state = 10`.
3. Bounce rejection: `btn_load` toggles high/low every 2 cycles for 20 cycles, then stays low -> no `press`, and `state`/`a_out` unchanged.
4. Hold: button held high for 50 cycles in LOAD_A -> exactly one capture. `state = 01`, not READY.
5. Clear priority: in LOAD_B, `clr` asserted on the same cycle `press` is high -> `state = 00`, `a_out = b_out = 0`, `valid = 0`, `done` never pulses.
6. Cycle back: in READY with A = 1011 and B = 0001, press -> `valid = 0`, `state = 00`, `a_out = 1011` and `b_out = 0001` retained. Next press with `sw = 0110` -> `a_out = 0110`.
